// File: rtl/cache_refill_fsm.sv
// Miss-handling sequencer: captures a missing line, requests it from memory,
// streams the returned words into the victim way, then commits tag/valid.
module cache_refill_fsm #(
    parameter int ADDR_SIZE      = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int NUM_WAYS       = 4,
    parameter int WORDS_PER_LINE = 4
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              req_valid,
    input  logic [ADDR_SIZE-1:0]              req_addr,
    input  logic                              hit,
    input  logic [$clog2(NUM_WAYS)-1:0]       victim_way,
    output logic                              stall,
    output logic                              mem_req_valid,
    input  logic                              mem_req_ready,
    output logic [ADDR_SIZE-1:0]              mem_req_addr,
    input  logic                              mem_resp_valid,
    input  logic [DATA_WIDTH-1:0]             mem_resp_data,
    output logic                              fill_we,
    output logic [$clog2(NUM_WAYS)-1:0]       fill_way,
    output logic [$clog2(WORDS_PER_LINE)-1:0] fill_word,
    output logic [DATA_WIDTH-1:0]             fill_data,
    output logic                              tag_we,
    output logic                              cru_update,
    output logic                              protocol_err,
    output logic [31:0]                       miss_count
);

    localparam int WAY_W    = $clog2(NUM_WAYS);
    localparam int WORD_W   = $clog2(WORDS_PER_LINE);
    localparam int OFF_BITS = $clog2(WORDS_PER_LINE * DATA_WIDTH / 8);

    typedef enum logic [1:0] {IDLE, REQ, FILL, COMMIT} state_t;

    state_t              state_q, state_d;
    logic [ADDR_SIZE-1:0] line_addr_q, line_addr;
    logic [WAY_W-1:0]     way_q;
    logic [WORD_W-1:0]    cnt_q;
    logic                 miss;

    always_comb begin
        line_addr                 = req_addr;
        line_addr[OFF_BITS-1:0]   = '0;
    end

    assign miss         = req_valid && !hit;
    assign mem_req_addr = line_addr_q;
    assign fill_way     = way_q;
    assign fill_word    = cnt_q;
    assign fill_data    = mem_resp_data;

    always_comb begin
        state_d       = state_q;
        stall         = 1'b1;
        mem_req_valid = 1'b0;
        fill_we       = 1'b0;
        tag_we        = 1'b0;
        cru_update    = 1'b0;
        case (state_q)
            IDLE: begin
                stall = miss;
                if (miss) state_d = REQ;
            end
            REQ: begin
                mem_req_valid = 1'b1;
                if (mem_req_ready) state_d = FILL;
            end
            FILL: begin
                if (mem_resp_valid) begin
                    fill_we = 1'b1;
                    if (cnt_q == WORD_W'(WORDS_PER_LINE - 1)) state_d = COMMIT;
                end
            end
            COMMIT: begin
                tag_we     = 1'b1;
                cru_update = 1'b1;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // Reset suppresses strobes in its own cycle so an aborted fill never commits.
        if (rst) begin
            state_d       = IDLE;
            mem_req_valid = 1'b0;
            fill_we       = 1'b0;
            tag_we        = 1'b0;
            cru_update    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            line_addr_q  <= '0;
            way_q        <= '0;
            cnt_q        <= '0;
            protocol_err <= 1'b0;
            miss_count   <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && miss) begin
                line_addr_q <= line_addr;
                way_q       <= victim_way;
                if (miss_count != '1) miss_count <= miss_count + 32'd1;
            end
            if (mem_req_valid && mem_req_ready) cnt_q <= '0;
            else if (fill_we)                   cnt_q <= cnt_q + 1'b1;
            if (mem_resp_valid && state_q != FILL) protocol_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_cache_refill_fsm.sv
// Directed bench for cache_refill_fsm: a per-cycle vector table for the basic
// miss sequence plus hand-written multi-cycle corner cases.
module tb_cache_refill_fsm;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic [31:0] req_addr;
    logic        hit;
    logic [1:0]  victim_way;
    logic        stall;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_req_addr;
    logic        mem_resp_valid;
    logic [31:0] mem_resp_data;
    logic        fill_we;
    logic [1:0]  fill_way;
    logic [1:0]  fill_word;
    logic [31:0] fill_data;
    logic        tag_we;
    logic        cru_update;
    logic        protocol_err;
    logic [31:0] miss_count;

    int errors = 0;
    int checks = 0;

    cache_refill_fsm #(
        .ADDR_SIZE(32), .DATA_WIDTH(32), .NUM_WAYS(4), .WORDS_PER_LINE(4)
    ) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr),
        .hit(hit), .victim_way(victim_way), .stall(stall),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_req_addr(mem_req_addr), .mem_resp_valid(mem_resp_valid),
        .mem_resp_data(mem_resp_data), .fill_we(fill_we), .fill_way(fill_way),
        .fill_word(fill_word), .fill_data(fill_data), .tag_we(tag_we),
        .cru_update(cru_update), .protocol_err(protocol_err),
        .miss_count(miss_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rv;
        logic [31:0] addr;
        logic        h;
        logic [1:0]  vw;
        logic        rdy;
        logic        respv;
        logic [31:0] data;
        logic        e_stall;
        logic        e_mrv;
        logic [31:0] e_maddr;
        logic        e_fwe;
        logic [1:0]  e_word;
        logic [1:0]  e_way;
        logic [31:0] e_fdata;
        logic        e_twe;
    } vec_t;

    vec_t vec [10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Inputs change on the falling edge; outputs are sampled 1ns later.
    task automatic drive(input logic rv, input logic [31:0] a, input logic h,
                         input logic [1:0] w, input logic rdy, input logic respv,
                         input logic [31:0] d);
        @(negedge clk);
        req_valid = rv; req_addr = a; hit = h; victim_way = w;
        mem_req_ready = rdy; mem_resp_valid = respv; mem_resp_data = d;
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        req_valid = 0; req_addr = '0; hit = 0; victim_way = '0;
        mem_req_ready = 0; mem_resp_valid = 0; mem_resp_data = '0;
        #1;
        chk("rst_tag_we", 32'(tag_we), 0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        int pulses;
        int w;

        vec[0] = '{1, 32'h1234, 0, 2, 0, 0, 0,        1, 0, 0, 0, 0, 0, 0, 0};
        vec[1] = '{0, 0, 0, 0, 1, 0, 0,               1, 1, 32'h1230, 0, 0, 0, 0, 0};
        vec[2] = '{0, 0, 0, 0, 0, 1, 32'h11,          1, 0, 0, 1, 0, 2, 32'h11, 0};
        vec[3] = '{0, 0, 1, 3, 0, 1, 32'h12,          1, 0, 0, 1, 1, 2, 32'h12, 0};
        vec[4] = '{1, 32'h9990, 0, 1, 0, 1, 32'h13,   1, 0, 0, 1, 2, 2, 32'h13, 0};
        vec[5] = '{0, 0, 0, 0, 0, 1, 32'h14,          1, 0, 0, 1, 3, 2, 32'h14, 0};
        vec[6] = '{0, 0, 0, 0, 0, 0, 0,               1, 0, 0, 0, 0, 0, 0, 1};
        vec[7] = '{1, 32'h1234, 1, 0, 0, 0, 0,        0, 0, 0, 0, 0, 0, 0, 0};
        vec[8] = '{1, 32'h5678, 0, 1, 0, 0, 0,        1, 0, 0, 0, 0, 0, 0, 0};
        vec[9] = '{0, 0, 0, 0, 0, 0, 0,               1, 1, 32'h5670, 0, 0, 0, 0, 0};

        rst = 1'b1;
        do_reset();

        // Reset state
        drive(0, 0, 0, 0, 0, 0, 0);
        chk("reset_stall", 32'(stall), 0);
        chk("reset_mrv", 32'(mem_req_valid), 0);
        chk("reset_fill_we", 32'(fill_we), 0);
        chk("reset_tag_we", 32'(tag_we), 0);
        chk("reset_cru", 32'(cru_update), 0);
        chk("reset_perr", 32'(protocol_err), 0);
        chk("reset_miss_count", miss_count, 0);

        // Zero-wait miss, replay hit, then back-to-back miss
        for (int i = 0; i < 10; i++) begin
            drive(vec[i].rv, vec[i].addr, vec[i].h, vec[i].vw, vec[i].rdy,
                  vec[i].respv, vec[i].data);
            chk($sformatf("v%0d_stall", i), 32'(stall), 32'(vec[i].e_stall));
            chk($sformatf("v%0d_mrv", i), 32'(mem_req_valid), 32'(vec[i].e_mrv));
            if (vec[i].e_mrv) chk($sformatf("v%0d_maddr", i), mem_req_addr, vec[i].e_maddr);
            chk($sformatf("v%0d_fill_we", i), 32'(fill_we), 32'(vec[i].e_fwe));
            if (vec[i].e_fwe) begin
                chk($sformatf("v%0d_fill_word", i), 32'(fill_word), 32'(vec[i].e_word));
                chk($sformatf("v%0d_fill_way", i), 32'(fill_way), 32'(vec[i].e_way));
                chk($sformatf("v%0d_fill_data", i), fill_data, vec[i].e_fdata);
            end
            chk($sformatf("v%0d_tag_we", i), 32'(tag_we), 32'(vec[i].e_twe));
            chk($sformatf("v%0d_cru", i), 32'(cru_update), 32'(vec[i].e_twe));
            if (i == 7) chk("v7_miss_count", miss_count, 1);
        end
        @(posedge clk); #1;
        chk("b2b_miss_count", miss_count, 2);

        // Backpressure: ready low for 3 REQ cycles, penalty 10
        do_reset();
        drive(1, 32'h0000_ABCD, 0, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            drive(0, 32'hFFFF_0000, 0, 3, 0, 0, 0);
            chk("bp_mrv_held", 32'(mem_req_valid), 1);
            chk("bp_maddr_held", mem_req_addr, 32'h0000_ABC0);
            chk("bp_no_fill", 32'(fill_we), 0);
        end
        drive(0, 0, 0, 0, 1, 0, 0);
        chk("bp_handshake_mrv", 32'(mem_req_valid), 1);
        for (int i = 0; i < 4; i++) begin
            drive(0, 0, 0, 0, 0, 1, 32'hB0 + 32'(i));
            chk("bp_fill_word", 32'(fill_word), 32'(i));
            chk("bp_fill_way", 32'(fill_way), 1);
        end
        cyc = 9;
        for (int i = 0; i < 20; i++) begin
            drive(1, 32'h0000_ABCD, 1, 0, 0, 0, 0);
            if (!stall) break;
            cyc++;
        end
        chk("bp_penalty", 32'(cyc), 10);

        // Gapped responses while victim_way/hit/req toggle
        do_reset();
        drive(1, 32'h0000_2004, 0, 3, 0, 0, 0);
        drive(0, 0, 0, 0, 1, 0, 0);
        pulses = 0;
        w = 0;
        for (int i = 0; i < 8; i++) begin
            drive(32'(i % 3 == 0), 32'h7000_0000, 32'(i % 2), 2'(i), 0,
                  32'(i % 2 == 1), 32'hA0 + 32'(w));
            if (fill_we) begin
                pulses++;
                chk("gap_fill_word", 32'(fill_word), 32'(w));
                chk("gap_fill_data", fill_data, 32'hA0 + 32'(w));
                chk("gap_fill_way", 32'(fill_way), 3);
                w++;
            end
            chk("gap_no_tag_we", 32'(tag_we), 0);
        end
        chk("gap_pulses", 32'(pulses), 4);
        drive(0, 0, 0, 0, 0, 0, 0);
        chk("gap_commit_tag_we", 32'(tag_we), 1);
        chk("gap_commit_cru", 32'(cru_update), 1);
        chk("gap_miss_count", miss_count, 1);

        // Reset during FILL after two words
        do_reset();
        drive(1, 32'h0000_3000, 0, 0, 1, 0, 0);
        drive(0, 0, 0, 0, 1, 0, 0);
        drive(0, 0, 0, 0, 0, 1, 32'hC0);
        drive(0, 0, 0, 0, 0, 1, 32'hC1);
        do_reset();
        chk("mid_rst_idle_stall", 32'(stall), 0);
        for (int i = 0; i < 3; i++) begin
            drive(1, 32'h0000_3000, 1, 0, 0, 0, 0);
            chk("mid_rst_stall", 32'(stall), 0);
            chk("mid_rst_tag_we", 32'(tag_we), 0);
            chk("mid_rst_fill_we", 32'(fill_we), 0);
            chk("mid_rst_miss_count", miss_count, 0);
        end

        // Stray response in IDLE sets sticky protocol_err
        do_reset();
        drive(0, 0, 0, 0, 0, 1, 32'hDEAD);
        chk("perr_no_fill", 32'(fill_we), 0);
        drive(0, 0, 0, 0, 0, 0, 0);
        chk("perr_set", 32'(protocol_err), 1);
        drive(1, 32'h0000_4444, 0, 1, 0, 0, 0);
        drive(0, 0, 0, 0, 1, 0, 0);
        for (int i = 0; i < 4; i++) drive(0, 0, 0, 0, 0, 1, 32'hE0 + 32'(i));
        drive(0, 0, 0, 0, 0, 0, 0);
        chk("perr_commit_tag_we", 32'(tag_we), 1);
        drive(0, 0, 0, 0, 0, 0, 0);
        chk("perr_sticky", 32'(protocol_err), 1);
        do_reset();
        drive(0, 0, 0, 0, 0, 0, 0);
        chk("perr_cleared", 32'(protocol_err), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cache_refill_fsm.md
# cache_refill_fsm

Miss-handling sequencer for the set-associative data cache. On a lookup miss it captures the line address and the victim way, issues one line-read request to backing memory, and streams the returned words into the selected way. It then commits tag and valid bit and releases the core stall so the access replays as a hit. It sits between the core load/store port, the cache controller (hit and victim way), and the memory bus.

## Interface
- ADDR_SIZE, 32, byte address width
- DATA_WIDTH, 32, memory word width in bits (multiple of 8)
- NUM_WAYS, 4, cache associativity (power of 2, ≥2)
- WORDS_PER_LINE, 4, words per cache line (power of 2, ≥2)

- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  core access (load or store) presented this cycle
- req_addr  in  ADDR_SIZE  core byte address
- hit  in  1  lookup hit from cache controller (same cycle as request)
- victim_way  in  $clog2(NUM_WAYS)  way selected for replacement by cache controller
- stall  out  1  hold core pipeline
- mem_req_valid  out  1  line-read request valid
- mem_req_ready  in  1  memory accepts request
- mem_req_addr  out  ADDR_SIZE  line-aligned byte address
- mem_resp_valid  in  1  one returned word valid
- mem_resp_data  in  DATA_WIDTH  returned word
- fill_we  out  1  write one word into data array
- fill_way  out  $clog2(NUM_WAYS)  way being filled
- fill_word  out  $clog2(WORDS_PER_LINE)  word index within line
- fill_data  out  DATA_WIDTH  word to write
- tag_we  out  1  write tag and set valid for (set of line addr, fill_way)
- cru_update  out  1  notify replacement unit that fill_way was used
- protocol_err  out  1  sticky: response received outside FILL
- miss_count  out  32  saturating count of misses accepted

## Operation
- LineOffsetBits = $clog2(WORDS_PER_LINE*DATA_WIDTH/8). line_addr = req_addr with the low LineOffsetBits forced to 0.
- States: IDLE, REQ, FILL, COMMIT. Reset → IDLE. On reset, word counter = 0, protocol_err = 0, miss_count = 0, and all strobe outputs = 0.
- IDLE: when req_valid && !hit, latch line_addr and victim_way, increment miss_count (saturating at 2^32−1), and go to REQ. Otherwise stay in IDLE.
- REQ: mem_req_valid = 1 and mem_req_addr = latched line_addr. Both are held stable until mem_req_ready. On the handshake cycle (valid && ready), clear the word counter and go to FILL.
- FILL: on each mem_resp_valid, pulse fill_we with fill_word = counter, fill_data = mem_resp_data, and fill_way = latched way, then increment the counter. A response arriving with counter = WORDS_PER_LINE−1 goes to COMMIT. Cycles without mem_resp_valid produce no writes and no state change.
- COMMIT: pulse tag_we and cru_update for exactly one cycle, then go to IDLE.
- Loads and stores miss identically (write-allocate). The store merge is done by the datapath on replay.
- mem_resp_valid in any state other than FILL sets protocol_err. The response is otherwise ignored and its data is not written. protocol_err clears only on rst.
- Outside the cycles listed above, fill_we, tag_we, cru_update and mem_req_valid are 0. fill_way, fill_word and fill_data are don't-care when fill_we = 0.

## Timing
- stall = (state ≠ IDLE) || (state == IDLE && req_valid && !hit). This is combinational, so a miss stalls in its own cycle.
- A hit in IDLE never stalls and adds no latency.
- With zero-wait memory (ready in the first REQ cycle, one response per cycle), the sequence is:
  - cycle 0: miss accepted;
  - cycle 1: REQ handshake;
  - cycles 2 to 1+WORDS_PER_LINE: fills;
  - cycle 2+WORDS_PER_LINE: COMMIT;
  - the next cycle: IDLE with stall = 0 if the replay hits.
- Miss-to-release penalty = WORDS_PER_LINE + 3 cycles, plus any memory wait cycles.
- The victim way is sampled only on the miss cycle. Later changes to victim_way or hit do not affect an in-flight fill.
- req_valid and req_addr changes during REQ, FILL or COMMIT are ignored.
- Reset mid-fill (any non-IDLE state): next state is IDLE, and tag_we is never asserted, so the partially filled line stays invalid. An outstanding memory response then arrives in IDLE and sets protocol_err; the bench must quiesce memory across reset.
- A miss accepted in the cycle immediately after COMMIT is legal: back-to-back misses occur without a bubble beyond IDLE.

## Test plan
- Zero-wait miss at addr 0x0000_1234 (defaults), victim_way = 2:
  - mem_req_addr = 0x0000_1230 in cycle 1;
  - fill_we pulses cycles 2–5 with fill_word 0,1,2,3 and fill_way = 2;
  - tag_we and cru_update in cycle 6;
  - stall low in cycle 7 with hit = 1;
  - miss_count = 1.
- Memory backpressure: mem_req_ready low for 3 cycles. mem_req_valid and mem_req_addr stay stable, there is no fill_we before the handshake, and the penalty is 10 cycles.
- Gapped responses (one every other cycle, data 0xA0..0xA3): exactly 4 fill_we pulses with matching data and words, and COMMIT follows the last response.
- victim_way and hit toggled during FILL: fill_way stays equal to the value latched at the miss.
- rst asserted during FILL after 2 words: next cycle IDLE, no tag_we, miss_count = 0, stall = 0 for a hitting request.
- mem_resp_valid pulsed in IDLE: protocol_err = 1 and no fill_we. It stays 1 through a subsequent normal miss until rst.
